alu_arbiter: RTL
================

# alu_arbiter

Two-requester arbiter and sequencer for the shared single-cycle 32-bit ALU (srca/srcb/alu_ctrl → alu_out). It accepts operation requests from two independent clients over valid/ready handshakes, grants the ALU round-robin, and registers operands into the ALU. It captures the result and returns it to the winning client over a valid/ready response channel. It sits between the ALU instance and its clients, for example a main datapath and a branch/address unit.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset; all state cleared immediately on assertion, released synchronously to clk
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this edge
- req0_srca / req1_srca  in  WIDTH  operand A
- req0_srcb / req1_srcb  in  WIDTH  operand B
- req0_ctrl / req1_ctrl  in  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- rsp0_valid / rsp1_valid  out  1  result available
- rsp0_ready / rsp1_ready  in  1  client takes result
- rsp0_data / rsp1_data  out  WIDTH  result
- alu_srca, alu_srcb  out  WIDTH  registered ALU operands
- alu_ctrl  out  3  registered ALU control
- alu_out  in  WIDTH  combinational ALU result

## Operation
- FSM states are IDLE, EXEC, RESP. The reset state is IDLE.
- IDLE:
  - If any req_valid is high, the arbiter picks a winner. reqN_ready = (state==IDLE) & grant==N, combinational.
  - On acceptance, the winner's srca/srcb/ctrl are latched into alu_srca/alu_srcb/alu_ctrl, and the winner index is latched. Next state is EXEC.
- EXEC: alu_out is captured into the result register. Next state is RESP.
- RESP:
  - rspN_valid=1 for the latched winner only. rspN_data = result; the other client's rsp_data = 0.
  - On rspN_valid & rspN_ready, the RR pointer is updated to the winner and the next state is IDLE.
- Round-robin: if both are valid, the requester not granted last wins. The pointer resets to "last=1", so req0 wins first.
- alu_ctrl codes 011/100/101 pass through unchanged. The ALU defines the result; the arbiter does not reject them.
- alu_* outputs hold their last values between operations. No arithmetic is performed here; widths pass straight through.
- Reset values: state IDLE, pointer last=1, alu_srca=0, alu_srcb=0, alu_ctrl=000, result=0, rsp*_valid=0, rsp*_data=0, req*_ready=0.

## Timing
- Accept at edge n → alu_* valid after edge n → result captured at edge n+1 → rspN_valid high from edge n+1.
- Response handshake at edge m → IDLE. The next accept occurs at edge m+1 at the earliest. Minimum is 3 cycles per op.
- Backpressure: rsp valid and data are held stable until ready. No other request is accepted meanwhile.
- A request deasserted before acceptance is dropped silently. No request is ever accepted in EXEC or RESP.
- Reset mid-operation (EXEC/RESP) aborts the op. No response is issued, and all outputs take their reset values asynchronously.

## Configuration
- ALU_ARB_LOCK_EN defined: adds inputs req0_lock and req1_lock (1 bit each), sampled with acceptance.
  - If the accepted op had lock=1, the next IDLE grants only the same requester. The other requester's ready stays 0, even if the locked client is idle.
  - The lock releases when that requester has an op accepted with lock=0.
  - Reset clears the lock.
- Without ALU_ARB_LOCK_EN: the lock ports do not exist and arbitration is pure round-robin.

## Structure
- Package alu_arb_pkg:
  - state enum {IDLE, EXEC, RESP}
  - ALU control constants ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111
- Sub-module rr_arb2: combinational 2-way round-robin grant from the valids, the last-grant bit and, when enabled, the lock state. The FSM and datapath registers stay in alu_arbiter.

## Test plan
- Reset: rst_n low, then release with no requests → all rsp_valid=0, req_ready=0, alu_ctrl=000, alu_srca=0, over 5 cycles.
- Single op: req0 ADD 10,15 → req0_ready at acceptance. rsp0_valid=1 with rsp0_data=25 one edge later; rsp1_valid stays 0.
- Contention: both valid at once, req0 SUB 15,10 and req1 ADD 3,4, rsp ready=1 → req0 is served first (5), then req1 (7). Reissuing both → req0 is served next.
- Backpressure: req1 OR 0xF0,0x0F with rsp1_ready=0 for 5 cycles → rsp1_valid/rsp1_data=0xFF held. req0_ready=0 throughout, and req0 is accepted 1 cycle after the handshake.
- Reset mid-op: rst_n asserted in EXEC → rsp outputs 0 immediately. After release, no stale response appears and a fresh req0 SLT 1,2 returns 1.
- Lock (ALU_ARB_LOCK_EN): req0 with lock=1 and req1 both valid → req0 is granted twice consecutively. After a req0 op with lock=0, req1 is granted next.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-client ALU arbiter.
package alu_arb_pkg;

    // Sequencer states: IDLE accepts, EXEC captures the ALU result, RESP returns it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_arb_state_e;

    // ALU control encodings understood by the shared ALU.
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant with optional lock ownership.
// When lock_active is set only lock_owner may be granted; otherwise the
// requester that was not served last wins a tie.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last,
    input  logic lock_active,
    input  logic lock_owner,
    output logic gnt0,
    output logic gnt1
);

    // One-hot grant selection from valids, last winner and lock state.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (lock_active) begin
            if (lock_owner) gnt1 = valid1;
            else            gnt0 = valid0;
        end else if (valid0 && valid1) begin
            if (last) gnt0 = 1'b1;
            else      gnt1 = 1'b1;
        end else begin
            gnt0 = valid0;
            gnt1 = valid1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer in front of a shared single-cycle ALU.
// Optional feature: define ALU_ARB_LOCK_EN to add req0_lock/req1_lock, which
// let a client keep exclusive ownership of the ALU across operations.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Requesters hold valid/operands until they see ready; ready is
// only ever high in IDLE for the granted client. Responses hold rsp valid and
// data stable until the client raises rsp ready.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_srca,
    input  logic [WIDTH-1:0] req0_srcb,
    input  logic [2:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_srca,
    input  logic [WIDTH-1:0] req1_srcb,
    input  logic [2:0]       req1_ctrl,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
`ifdef ALU_ARB_LOCK_EN
    input  logic             req0_lock,
    input  logic             req1_lock,
`endif
    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    output alu_arb_state_e   dbg_state
);

    alu_arb_state_e   state_q, state_d;
    logic             last_q;
    logic             winner_q;
    logic [WIDTH-1:0] result_q;
    logic             gnt0, gnt1;
    logic             accept;
    logic             rsp_hs;
    logic             lock_active;
    logic             lock_owner;

    rr_arb2 u_rr_arb2 (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last        (last_q),
        .lock_active (lock_active),
        .lock_owner  (lock_owner),
        .gnt0        (gnt0),
        .gnt1        (gnt1)
    );

    assign req0_ready = (state_q == IDLE) && gnt0;
    assign req1_ready = (state_q == IDLE) && gnt1;
    assign accept     = req0_ready || req1_ready;

    assign rsp0_valid = (state_q == RESP) && !winner_q;
    assign rsp1_valid = (state_q == RESP) &&  winner_q;
    assign rsp0_data  = rsp0_valid ? result_q : '0;
    assign rsp1_data  = rsp1_valid ? result_q : '0;
    assign rsp_hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    assign dbg_state  = state_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: one accept, one execute cycle, then hold until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand registers, winner, result capture and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_srca <= '0;
            alu_srcb <= '0;
            alu_ctrl <= ALU_AND;
            winner_q <= 1'b0;
            result_q <= '0;
            last_q   <= 1'b1;
        end else begin
            if (accept) begin
                winner_q <= gnt1;
                if (gnt1) begin
                    alu_srca <= req1_srca;
                    alu_srcb <= req1_srcb;
                    alu_ctrl <= req1_ctrl;
                end else begin
                    alu_srca <= req0_srca;
                    alu_srcb <= req0_srcb;
                    alu_ctrl <= req0_ctrl;
                end
            end
            if (state_q == EXEC) result_q <= alu_out;
            // The pointer moves only once the result is delivered.
            if (rsp_hs) last_q <= winner_q;
        end
    end

`ifdef ALU_ARB_LOCK_EN
    logic lock_active_q;
    logic lock_owner_q;

    // Lock follows the lock bit of every accepted op; only the owner can be
    // accepted while locked, so an unlocked op from the owner releases it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_active_q <= 1'b0;
            lock_owner_q  <= 1'b0;
        end else if (accept) begin
            lock_active_q <= gnt1 ? req1_lock : req0_lock;
            lock_owner_q  <= gnt1;
        end
    end

    assign lock_active = lock_active_q;
    assign lock_owner  = lock_owner_q;
`else
    assign lock_active = 1'b0;
    assign lock_owner  = 1'b0;
`endif

endmodule
